gf180mcu_fd_sc_mcu9t5v0__holdbus: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__holdbus.sv | 133 +++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__holdbus.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__holdbus.sv
// Clocked bus keeper: samples a shared tri-state bus while it is driven and
// weakly re-drives the last value once every driver has released it.
module gf180mcu_fd_sc_mcu9t5v0__holdbus #(
  parameter int                WIDTH     = 8,
  parameter int                TIMEOUT   = 15,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] BUS_I,
  input  logic             DRV_EN,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] BUS_O,
  output logic             KEEP_EN,
  output logic             FLOAT,
  output logic             STALE,
  output logic [1:0]       STATE_DBG
);

  localparam logic [1:0] ST_DRIVEN  = 2'd0;
  localparam logic [1:0] ST_KEEP    = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;
  localparam logic [1:0] ST_OFF     = 2'd3;

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_RELEASE = 2'b01;
  localparam logic [1:0] MODE_OFF     = 2'b11;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] held_q,  held_d;
  logic [WIDTH-1:0] bus_q,   bus_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             keep_q,  keep_d;
  logic             float_q, float_d;
  logic             stale_q, stale_d;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    bus_d   = bus_q;
    cnt_d   = cnt_q;
    keep_d  = keep_q;
    float_d = 1'b0;
    stale_d = stale_q;

    if (DRV_EN) begin
      // An active driver always wins and refreshes the sampled value.
      state_d = ST_DRIVEN;
      held_d  = BUS_I;
      cnt_d   = '0;
      keep_d  = 1'b0;
      stale_d = 1'b0;
    end else begin
      case (state_q)
        ST_DRIVEN: begin
          float_d = 1'b1;
          cnt_d   = '0;
          if (MODE == MODE_OFF) begin
            state_d = ST_OFF;
            keep_d  = 1'b0;
          end else begin
            state_d = ST_KEEP;
            keep_d  = 1'b1;
            bus_d   = held_q;
          end
        end
        ST_KEEP: begin
          if (MODE == MODE_OFF) begin
            state_d = ST_OFF;
            keep_d  = 1'b0;
          end else if (MODE != MODE_HOLD) begin
            // Expiry is detected before incrementing so cnt tops out at TIMEOUT-1.
            if (cnt_q == CNT_LAST) begin
              state_d = ST_EXPIRED;
              stale_d = 1'b1;
              if (MODE == MODE_RELEASE) begin
                keep_d = 1'b0;
              end else begin
                keep_d = 1'b1;
                bus_d  = RESET_VAL;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_EXPIRED: begin
          if (MODE == MODE_HOLD) begin
            keep_d = 1'b1;
          end else if (MODE == MODE_OFF) begin
            state_d = ST_OFF;
            keep_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_OFF;
          keep_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_OFF;
      held_q  <= RESET_VAL;
      bus_q   <= RESET_VAL;
      cnt_q   <= '0;
      keep_q  <= 1'b0;
      float_q <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      bus_q   <= bus_d;
      cnt_q   <= cnt_d;
      keep_q  <= keep_d;
      float_q <= float_d;
      stale_q <= stale_d;
    end
  end

  // Combinational mask so the keeper can never fight a driver that just turned on.
  assign KEEP_EN   = keep_q & ~DRV_EN;
  assign BUS_O     = bus_q;
  assign FLOAT     = float_q;
  assign STALE     = stale_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__holdbus.sv
// Directed bench for the bus keeper: a vector table plus hand-written
// sequences for mid-cycle re-drive, asynchronous reset and contention.
module tb_gf180mcu_fd_sc_mcu9t5v0__holdbus;

  localparam logic [1:0] ST_DRIVEN = 2'd0;
  localparam logic [1:0] ST_OFF    = 2'd3;

  logic       clk;
  logic       rn;
  logic [7:0] bus_i;
  logic       drv_en;
  logic [1:0] mode;
  logic [7:0] bus_o;
  logic       keep_en;
  logic       float_o;
  logic       stale;
  logic [1:0] state_dbg;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       drv;
    logic [7:0] bus;
    logic [1:0] mode;
    int         cycles;
    logic [7:0] exp_bus;
    logic       exp_keep;
    logic       exp_float;
    logic       exp_stale;
  } vec_t;

  vec_t vecs[$];

  gf180mcu_fd_sc_mcu9t5v0__holdbus #(
    .WIDTH    (8),
    .TIMEOUT  (4),
    .RESET_VAL(8'h00)
  ) dut (
    .CLK      (clk),
    .RN       (rn),
    .BUS_I    (bus_i),
    .DRV_EN   (drv_en),
    .MODE     (mode),
    .BUS_O    (bus_o),
    .KEEP_EN  (keep_en),
    .FLOAT    (float_o),
    .STALE    (stale),
    .STATE_DBG(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic [7:0] b, input logic [1:0] m);
    drv_en = d;
    bus_i  = b;
    mode   = m;
  endtask

  task automatic add(input string name, input logic d, input logic [7:0] b, input logic [1:0] m,
                     input int cyc, input logic [7:0] eb, input logic ek, input logic ef,
                     input logic es);
    vec_t v;
    v.name = name; v.drv = d; v.bus = b; v.mode = m; v.cycles = cyc;
    v.exp_bus = eb; v.exp_keep = ek; v.exp_float = ef; v.exp_stale = es;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic [7:0] eb, input logic ek,
                            input logic ef, input logic es);
    check({name, ".bus_o"},   32'(bus_o),   32'(eb));
    check({name, ".keep_en"}, 32'(keep_en), 32'(ek));
    check({name, ".float"},   32'(float_o), 32'(ef));
    check({name, ".stale"},   32'(stale),   32'(es));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //                name              drv bus    mode  cyc bus_o  keep flt stale
    add("post_reset_off",  1'b0, 8'h00, 2'b00, 1,   8'h00, 1'b0, 1'b0, 1'b0);
    add("drive_a5",        1'b1, 8'hA5, 2'b00, 1,   8'h00, 1'b0, 1'b0, 1'b0);
    add("release_a5",      1'b0, 8'h00, 2'b00, 1,   8'hA5, 1'b1, 1'b1, 1'b0);
    add("hold_a5_next",    1'b0, 8'h00, 2'b00, 1,   8'hA5, 1'b1, 1'b0, 1'b0);
    add("hold_forever",    1'b0, 8'h00, 2'b00, 100, 8'hA5, 1'b1, 1'b0, 1'b0);
    add("drive_3c",        1'b1, 8'h3C, 2'b01, 1,   8'hA5, 1'b0, 1'b0, 1'b0);
    add("rel_3c_n",        1'b0, 8'h00, 2'b01, 1,   8'h3C, 1'b1, 1'b1, 1'b0);
    add("rel_3c_n1",       1'b0, 8'h00, 2'b01, 1,   8'h3C, 1'b1, 1'b0, 1'b0);
    add("rel_3c_n3",       1'b0, 8'h00, 2'b01, 2,   8'h3C, 1'b1, 1'b0, 1'b0);
    add("rel_3c_expire",   1'b0, 8'h00, 2'b01, 1,   8'h3C, 1'b0, 1'b0, 1'b1);
    add("rel_3c_after",    1'b0, 8'h00, 2'b01, 5,   8'h3C, 1'b0, 1'b0, 1'b1);
    add("drive_ff",        1'b1, 8'hFF, 2'b10, 1,   8'h3C, 1'b0, 1'b0, 1'b0);
    add("park_ff_n",       1'b0, 8'h00, 2'b10, 1,   8'hFF, 1'b1, 1'b1, 1'b0);
    add("park_ff_n3",      1'b0, 8'h00, 2'b10, 3,   8'hFF, 1'b1, 1'b0, 1'b0);
    add("park_expire",     1'b0, 8'h00, 2'b10, 1,   8'h00, 1'b1, 1'b0, 1'b1);
    add("redrive_11",      1'b1, 8'h11, 2'b10, 1,   8'h00, 1'b0, 1'b0, 1'b0);
    add("rel_11",          1'b0, 8'h00, 2'b01, 1,   8'h11, 1'b1, 1'b1, 1'b0);
    add("rel_11_expire",   1'b0, 8'h00, 2'b01, 4,   8'h11, 1'b0, 1'b0, 1'b1);
    add("expired_to_hold", 1'b0, 8'h00, 2'b00, 1,   8'h11, 1'b1, 1'b0, 1'b1);
    add("expired_hold_2",  1'b0, 8'h00, 2'b00, 3,   8'h11, 1'b1, 1'b0, 1'b1);
    add("expired_to_off",  1'b0, 8'h00, 2'b11, 1,   8'h11, 1'b0, 1'b0, 1'b1);
    add("drive_5a",        1'b1, 8'h5A, 2'b00, 1,   8'h11, 1'b0, 1'b0, 1'b0);
    add("gap1_5a",         1'b0, 8'h00, 2'b00, 1,   8'h5A, 1'b1, 1'b1, 1'b0);
    add("gap1_end",        1'b1, 8'h5A, 2'b00, 1,   8'h5A, 1'b0, 1'b0, 1'b0);
    add("gap2_5a",         1'b0, 8'h00, 2'b00, 1,   8'h5A, 1'b1, 1'b1, 1'b0);
    add("drive_66",        1'b1, 8'h66, 2'b00, 1,   8'h5A, 1'b0, 1'b0, 1'b0);
    add("keep_66",         1'b0, 8'h00, 2'b00, 1,   8'h66, 1'b1, 1'b1, 1'b0);
    add("keep_to_off",     1'b0, 8'h00, 2'b11, 1,   8'h66, 1'b0, 1'b0, 1'b0);
    add("off_sticky",      1'b0, 8'h00, 2'b00, 3,   8'h66, 1'b0, 1'b0, 1'b0);
    add("drive_77_m11",    1'b1, 8'h77, 2'b11, 1,   8'h66, 1'b0, 1'b0, 1'b0);
    add("driven_to_off",   1'b0, 8'h00, 2'b11, 1,   8'h66, 1'b0, 1'b1, 1'b0);
    add("off_quiet",       1'b0, 8'h00, 2'b11, 1,   8'h66, 1'b0, 1'b0, 1'b0);

    // Reset with random inputs
    rn = 1'b0;
    drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    #2;
    check_outs("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(2);
    drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    tick(1);
    check_outs("reset_held", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_state", 32'(state_dbg), 32'(ST_OFF));
    drive(1'b0, 8'h00, 2'b00);
    rn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].drv, vecs[i].bus, vecs[i].mode);
      tick(vecs[i].cycles);
      check_outs(vecs[i].name, vecs[i].exp_bus, vecs[i].exp_keep, vecs[i].exp_float,
                 vecs[i].exp_stale);
    end
    check("off_after_table", 32'(state_dbg), 32'(ST_OFF));

    // Mid-cycle re-drive while keeping
    drive(1'b1, 8'hA5, 2'b00); tick(1);
    drive(1'b0, 8'h00, 2'b00); tick(2);
    check("contend_keep_before", 32'(keep_en), 32'd1);
    #3 drive(1'b1, 8'hC7, 2'b00);
    #1 check("contend_keep_comb", 32'(keep_en), 32'd0);
    tick(1);
    check("contend_keep_state", 32'(state_dbg), 32'(ST_DRIVEN));
    check_outs("contend_keep_edge", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Mid-cycle re-drive while parked
    drive(1'b0, 8'h00, 2'b10); tick(5);
    check_outs("park_c7", 8'h00, 1'b1, 1'b0, 1'b1);
    #3 drive(1'b1, 8'h11, 2'b10);
    #1 check("park_redrive_comb", 32'(keep_en), 32'd0);
    check("park_redrive_stale_reg", 32'(stale), 32'd1);
    tick(1);
    check_outs("park_redrive_edge", 8'h00, 1'b0, 1'b0, 1'b0);

    // RN pulse during EXPIRED
    drive(1'b1, 8'hC3, 2'b01); tick(1);
    drive(1'b0, 8'h00, 2'b01); tick(5);
    check_outs("pre_rn_expired", 8'hC3, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 2'b00); tick(1);
    check_outs("pre_rn_hold", 8'hC3, 1'b1, 1'b0, 1'b1);
    #2 rn = 1'b0;
    #1 check_outs("rn_mid_expired", 8'h00, 1'b0, 1'b0, 1'b0);
    check("rn_mid_state", 32'(state_dbg), 32'(ST_OFF));
    #1 rn = 1'b1;
    tick(1);
    check_outs("rn_release_off", 8'h00, 1'b0, 1'b0, 1'b0);

    // Random contention guard: KEEP_EN must never be high with DRV_EN high
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)));
      #1 check("guard_early", 32'(keep_en & drv_en), 32'd0);
      #2 drv_en = 1'($urandom_range(0, 1));
      #1 check("guard_mid", 32'(keep_en & drv_en), 32'd0);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
